// File: rtl/cache_address_arbiter_if.sv
// Requester-side bus of the cache address arbiter: per-port requests and
// addresses in, registered one-hot grant and selected address out.
interface cache_address_arbiter_if #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int NUM_PORTS     = 2
);
   localparam int INDEX_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0]               Req;
   logic [NUM_PORTS*ADDRESS_WIDTH-1:0] ReqAddress;
   logic [NUM_PORTS-1:0]               Grant;
   logic [INDEX_WIDTH-1:0]             GrantIndex;
   logic [ADDRESS_WIDTH-1:0]           Address;
   logic                               AddressValid;

   // Requesters drive requests and addresses and observe the grant.
   modport master (
      output Req, ReqAddress,
      input  Grant, GrantIndex, Address, AddressValid
   );

   // The arbiter samples requests and drives the registered address port.
   modport slave (
      input  Req, ReqAddress,
      output Grant, GrantIndex, Address, AddressValid
   );
endinterface

// File: rtl/cache_address_arbiter.sv
// Registered N-way address arbiter in front of the cache/DDR address port.
// Fixed-priority or round-robin selection, burst ownership while Req stays
// high, same-edge handover on release and an optional hold limit.
module cache_address_arbiter #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int NUM_PORTS     = 2,
   parameter int MODE          = 0,
   parameter int MAX_HOLD      = 0
) (
   input logic                    clk,
   input logic                    rst,
   cache_address_arbiter_if.slave bus
);
   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]               state_q;
   logic [IW-1:0]            ptr_q;
   logic [CW-1:0]            hold_q;
   logic [NUM_PORTS-1:0]     grant_q;
   logic [IW-1:0]            index_q;
   logic [ADDRESS_WIDTH-1:0] address_q;

   logic [ADDRESS_WIDTH-1:0] req_addr [NUM_PORTS];
   logic [NUM_PORTS-1:0]     mask;
   logic [IW-1:0]            start;
   logic [IW-1:0]            win;
   logic [IW-1:0]            ptr_next;
   logic [NUM_PORTS-1:0]     win_onehot;
   logic                     found;
   logic                     holder_req;
   logic                     limit_hit;
   logic [IW:0]              cand;

   assign bus.Grant        = grant_q;
   assign bus.GrantIndex   = index_q;
   assign bus.Address      = address_q;
   assign bus.AddressValid = (state_q == ST_BUSY);

   // Pick the next winner: search from the pointer (or port 0), skipping the
   // holder once it has used up its hold allowance.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      mask       = bus.Req;
      start      = '0;
      win        = '0;
      found      = 1'b0;
      cand       = '0;
      holder_req = bus.Req[index_q];
      limit_hit  = (MAX_HOLD > 0) && (state_q == ST_BUSY) && holder_req &&
                   (hold_q == CW'(MAX_HOLD - 1));
      for (int i = 0; i < NUM_PORTS; i++)
         req_addr[i] = bus.ReqAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (limit_hit)
         mask[index_q] = 1'b0;
      if (MODE == 1)
         start = ptr_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = {1'b0, start} + (IW+1)'(i);
         if (cand >= (IW+1)'(NUM_PORTS))
            cand = cand - (IW+1)'(NUM_PORTS);
         if (!found && mask[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
      ptr_next   = (win == IW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
      win_onehot = NUM_PORTS'(1) << win;
   end

   // Grant/ownership state machine; all outputs come straight from these flops.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         index_q   <= '0;
         address_q <= '0;
      end else begin
         if (state_q == ST_BUSY && holder_req && !limit_hit) begin
            // Holder continues its burst; address tracks the holder every cycle.
            address_q <= req_addr[index_q];
            if (MAX_HOLD > 0)
               hold_q <= hold_q + 1'b1;
         end else if (found) begin
            // New grant: from IDLE, on release, or forced by the hold limit.
            state_q   <= ST_BUSY;
            grant_q   <= win_onehot;
            index_q   <= win;
            address_q <= req_addr[win];
            hold_q    <= '0;
            if (MODE == 1)
               ptr_q <= ptr_next;
         end else if (state_q == ST_BUSY && holder_req) begin
            // Hold limit reached with no contender: holder keeps the bus.
            address_q <= req_addr[index_q];
            hold_q    <= '0;
         end else begin
            // Nobody requests: drop the grant, keep the last address on the bus.
            state_q <= ST_IDLE;
            grant_q <= '0;
            index_q <= '0;
            hold_q  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_cache_address_arbiter.sv
// Directed bench for cache_address_arbiter: three instances cover fixed
// priority (4 ports), round robin (3 ports) and a hold limit of 4 (2 ports).
module tb_cache_address_arbiter;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   cache_address_arbiter_if #(.ADDRESS_WIDTH(10), .NUM_PORTS(4)) a_if ();
   cache_address_arbiter_if #(.ADDRESS_WIDTH(10), .NUM_PORTS(3)) b_if ();
   cache_address_arbiter_if #(.ADDRESS_WIDTH(10), .NUM_PORTS(2)) c_if ();

   cache_address_arbiter #(.ADDRESS_WIDTH(10), .NUM_PORTS(4), .MODE(0), .MAX_HOLD(0))
      dut_a (.clk(clk), .rst(rst), .bus(a_if));
   cache_address_arbiter #(.ADDRESS_WIDTH(10), .NUM_PORTS(3), .MODE(1), .MAX_HOLD(0))
      dut_b (.clk(clk), .rst(rst), .bus(b_if));
   cache_address_arbiter #(.ADDRESS_WIDTH(10), .NUM_PORTS(2), .MODE(0), .MAX_HOLD(4))
      dut_c (.clk(clk), .rst(rst), .bus(c_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int port, input logic [9:0] v);
      a_if.ReqAddress[port*10 +: 10] = v;
   endtask

   initial begin
      rst = 1'b1;
      a_if.Req = 4'b1111;
      b_if.Req = 3'b111;
      c_if.Req = 2'b11;
      for (int i = 0; i < 4; i++) set_a(i, 10'h200 + 10'(i));
      for (int i = 0; i < 3; i++) b_if.ReqAddress[i*10 +: 10] = 10'h050 + 10'(i);
      c_if.ReqAddress = {10'h155, 10'h0AA};

      // Reset held with every request high.
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rst_a_grant", a_if.Grant, 4'b0000);
         check("rst_a_addr", a_if.Address, 10'h000);
         check("rst_a_valid", a_if.AddressValid, 1'b0);
         check("rst_a_index", a_if.GrantIndex, 2'd0);
         check("rst_b_grant", b_if.Grant, 3'b000);
         check("rst_c_grant", c_if.Grant, 2'b00);
      end
      rst = 1'b0;
      tick();
      check("rel_a_grant", a_if.Grant, 4'b0001);
      check("rel_a_addr", a_if.Address, 10'h200);
      check("rel_a_valid", a_if.AddressValid, 1'b1);
      check("rel_b_grant", b_if.Grant, 3'b001);
      check("rel_c_grant", c_if.Grant, 2'b01);
      a_if.Req = '0; b_if.Req = '0; c_if.Req = '0;
      tick();
      check("idle_a_grant", a_if.Grant, 4'b0000);
      check("idle_a_valid", a_if.AddressValid, 1'b0);
      check("idle_a_addr", a_if.Address, 10'h200);
      check("idle_b_grant", b_if.Grant, 3'b000);

      // Fixed priority: ports 1 and 3, then handover without a bubble.
      set_a(1, 10'h011);
      set_a(3, 10'h033);
      a_if.Req = 4'b1010;
      tick();
      check("fp_grant1", a_if.Grant, 4'b0010);
      check("fp_addr1", a_if.Address, 10'h011);
      check("fp_index1", a_if.GrantIndex, 2'd1);
      tick();
      check("fp_hold1", a_if.Grant, 4'b0010);
      a_if.Req = 4'b1000;
      tick();
      check("fp_grant3", a_if.Grant, 4'b1000);
      check("fp_addr3", a_if.Address, 10'h033);
      check("fp_index3", a_if.GrantIndex, 2'd3);
      check("fp_valid3", a_if.AddressValid, 1'b1);
      a_if.Req = 4'b1001;
      tick();
      check("fp_no_preempt", a_if.Grant, 4'b1000);
      a_if.Req = 4'b0001;
      tick();
      check("fp_grant0", a_if.Grant, 4'b0001);
      check("fp_addr0", a_if.Address, 10'h200);
      a_if.Req = 4'b0000;
      tick();
      check("fp_idle_grant", a_if.Grant, 4'b0000);
      check("fp_idle_index", a_if.GrantIndex, 2'd0);

      // Burst tracking on port 2: 0x100..0x107, one cycle behind.
      set_a(2, 10'h100);
      a_if.Req = 4'b0100;
      tick();
      check("burst_grant", a_if.Grant, 4'b0100);
      check("burst_addr0", a_if.Address, 10'h100);
      for (int i = 1; i < 8; i++) begin
         set_a(2, 10'h100 + 10'(i));
         tick();
         check("burst_addr", a_if.Address, 32'h100 + 32'(i));
      end
      a_if.Req = 4'b0000;
      set_a(2, 10'h000);
      tick();
      check("burst_end_valid", a_if.AddressValid, 1'b0);
      check("burst_end_grant", a_if.Grant, 4'b0000);
      check("burst_end_addr", a_if.Address, 10'h107);

      // Round robin: clear the pointer, then each holder releases after 2 cycles.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      b_if.Req = 3'b111;
      tick();
      check("rr_grant_0", b_if.Grant, 3'b001);
      check("rr_addr_0", b_if.Address, 10'h050);
      tick();
      check("rr_hold_0", b_if.Grant, 3'b001);
      b_if.Req = 3'b110;
      tick();
      check("rr_grant_1", b_if.Grant, 3'b010);
      check("rr_index_1", b_if.GrantIndex, 2'd1);
      b_if.Req = 3'b111;
      tick();
      check("rr_hold_1", b_if.Grant, 3'b010);
      b_if.Req = 3'b101;
      tick();
      check("rr_grant_2", b_if.Grant, 3'b100);
      check("rr_addr_2", b_if.Address, 10'h052);
      b_if.Req = 3'b111;
      tick();
      check("rr_hold_2", b_if.Grant, 3'b100);
      b_if.Req = 3'b011;
      tick();
      check("rr_wrap_0", b_if.Grant, 3'b001);
      check("rr_wrap_index", b_if.GrantIndex, 2'd0);
      b_if.Req = 3'b000;
      tick();
      check("rr_idle", b_if.Grant, 3'b000);

      // Hold limit of 4 with two continuous requesters, then port 0 alone.
      c_if.Req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("hold_p0", c_if.Grant, 2'b01);
      end
      tick();
      check("hold_switch_p1", c_if.Grant, 2'b10);
      check("hold_switch_addr", c_if.Address, 10'h155);
      check("hold_switch_index", c_if.GrantIndex, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold_p1", c_if.Grant, 2'b10);
      end
      tick();
      check("hold_back_p0", c_if.Grant, 2'b01);
      c_if.Req = 2'b01;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("hold_alone_p0", c_if.Grant, 2'b01);
      end
      c_if.Req = 2'b00;
      tick();
      check("hold_idle", c_if.Grant, 2'b00);

      // Mid-burst reset on A (fixed) and B (round robin, pointer must restart at 0).
      set_a(2, 10'h0C2);
      a_if.Req = 4'b1100;
      b_if.Req = 3'b010;
      tick();
      check("mrst_a_pre", a_if.Grant, 4'b0100);
      check("mrst_b_pre", b_if.Grant, 3'b010);
      b_if.Req = 3'b110;
      tick();
      check("mrst_b_keep", b_if.Grant, 3'b010);
      rst = 1'b1;
      tick();
      check("mrst_a_grant", a_if.Grant, 4'b0000);
      check("mrst_a_addr", a_if.Address, 10'h000);
      check("mrst_a_valid", a_if.AddressValid, 1'b0);
      check("mrst_a_index", a_if.GrantIndex, 2'd0);
      check("mrst_b_grant", b_if.Grant, 3'b000);
      check("mrst_b_addr", b_if.Address, 10'h000);
      rst = 1'b0;
      tick();
      check("mrst_a_regrant", a_if.Grant, 4'b0100);
      check("mrst_a_readdr", a_if.Address, 10'h0C2);
      check("mrst_b_regrant", b_if.Grant, 3'b010);
      check("mrst_b_index", b_if.GrantIndex, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
